// File: rtl/battleship_input_pkg.sv
// Shared types and default timing constants for the Battleship push-button front end.
// Defaults assume a 50 MHz board clock.
package battleship_input_pkg;

  typedef enum logic [2:0] {
    BTN_UP                 = 3'd0,
    BTN_DOWN               = 3'd1,
    BTN_LEFT               = 3'd2,
    BTN_RIGHT              = 3'd3,
    BTN_CONFIRM_AMOUNT     = 3'd4,
    BTN_CONFIRM_COLOCATION = 3'd5,
    BTN_CONFIRM_ATTACK     = 3'd6
  } btn_idx_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMING    = 2'd1,
    ST_HELD      = 2'd2,
    ST_RELEASING = 2'd3
  } btn_state_e;

  localparam int         DEF_N_BTN           = 7;
  localparam int         DEF_DEBOUNCE_CYCLES = 500000;    // 10 ms
  localparam int         DEF_REPEAT_DELAY    = 25000000;  // 500 ms
  localparam int         DEF_REPEAT_PERIOD   = 10000000;  // 200 ms
  localparam logic [6:0] DEF_REPEAT_MASK     = 7'b0001111;

  // Width able to hold max_count with a spare bit, so saturation never wraps.
  function automatic int cnt_width(input int max_count);
    return $clog2(max_count) + 1;
  endfunction

endpackage

// File: rtl/battleship_input_conditioner_if.sv
// Raw button inputs and conditioned pulse/level outputs of the conditioner.
interface battleship_input_conditioner_if #(
  parameter int N_BTN = 7
);
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_pulse;
  logic [N_BTN-1:0] btn_level;

  modport master (output btn_raw, input btn_pulse, input btn_level);
  modport slave  (input btn_raw, output btn_pulse, output btn_level);
endinterface

// File: rtl/btn_channel.sv
// One button: 2-FF synchroniser, debounce FSM and optional auto-repeat.
// Pulse and level outputs are registered and clear asynchronously on rst low.
module btn_channel
  import battleship_input_pkg::*;
#(
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse,
  output logic level
);

  localparam int              DB_W           = cnt_width(DEBOUNCE_CYCLES);
  localparam int              RP_W           = cnt_width(REPEAT_DELAY);
  localparam logic [DB_W-1:0] DB_LAST        = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_MAX         = '1;
  localparam logic [DB_W-1:0] DB_ONE         = DB_W'(1);
  localparam logic [RP_W-1:0] RP_DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);
  localparam logic [RP_W-1:0] RP_MAX         = '1;
  localparam logic [RP_W-1:0] RP_ONE         = RP_W'(1);
  localparam logic            RAW_RELEASED   = ACTIVE_LOW;

  logic [1:0]      sync_r;
  logic            pressed_s;
  btn_state_e      state_r, state_s;
  logic [DB_W-1:0] db_cnt_r, db_cnt_s, db_inc_s;
  logic [RP_W-1:0] rp_cnt_r, rp_cnt_s, rp_inc_s, rp_last_s;
  logic            rp_phase_r, rp_phase_s, rp_fire_s;
  logic            pulse_s, level_s, pulse_r, level_r;

  // Two-stage synchroniser, cleared to the released raw level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_r <= {2{RAW_RELEASED}};
    end else begin
      sync_r <= {sync_r[0], raw};
    end
  end

  assign pressed_s = sync_r[1] ^ ACTIVE_LOW;
  assign db_inc_s  = (db_cnt_r == DB_MAX) ? db_cnt_r : db_cnt_r + DB_ONE;
  assign rp_inc_s  = (rp_cnt_r == RP_MAX) ? rp_cnt_r : rp_cnt_r + RP_ONE;
  // Phase 0 waits out the initial delay, phase 1 the steady repeat period
  assign rp_last_s = rp_phase_r ? RP_PERIOD_LAST : RP_DELAY_LAST;

  // FSM state and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      db_cnt_r   <= '0;
      rp_cnt_r   <= '0;
      rp_phase_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      db_cnt_r   <= db_cnt_s;
      rp_cnt_r   <= rp_cnt_s;
      rp_phase_r <= rp_phase_s;
    end
  end

  // Next-state, debounce and repeat counter logic
  always_comb begin
    state_s    = state_r;
    db_cnt_s   = db_cnt_r;
    rp_cnt_s   = rp_cnt_r;
    rp_phase_s = rp_phase_r;
    rp_fire_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pressed_s) begin
          state_s  = ST_ARMING;
          db_cnt_s = '0;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_ARMING: begin
        if (!pressed_s) begin
          state_s = ST_IDLE;
        end else if (db_cnt_r == DB_LAST) begin
          state_s    = ST_HELD;
          rp_cnt_s   = '0;
          rp_phase_s = 1'b0;
        end else begin
          db_cnt_s = db_inc_s;
        end
      end
      ST_HELD: begin
        if (!pressed_s) begin
          state_s  = ST_RELEASING;
          db_cnt_s = '0;
        end else if (!REPEAT_EN) begin
          rp_cnt_s = '0;
        end else if (rp_cnt_r == rp_last_s) begin
          rp_fire_s  = 1'b1;
          rp_cnt_s   = '0;
          rp_phase_s = 1'b1;
        end else begin
          rp_cnt_s = rp_inc_s;
        end
      end
      ST_RELEASING: begin
        // A bounce back to pressed resumes HELD from the initial-delay phase
        if (pressed_s) begin
          state_s    = ST_HELD;
          rp_cnt_s   = '0;
          rp_phase_s = 1'b0;
        end else if (db_cnt_r == DB_LAST) begin
          state_s = ST_IDLE;
        end else begin
          db_cnt_s = db_inc_s;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state
  always_comb begin
    pulse_s = 1'b0;
    level_s = 1'b0;
    case (state_s)
      ST_HELD: begin
        level_s = 1'b1;
        pulse_s = (state_r == ST_ARMING) | rp_fire_s;
      end
      ST_RELEASING: begin
        level_s = 1'b1;
      end
      ST_IDLE, ST_ARMING: begin
        level_s = 1'b0;
      end
      default: begin
        level_s = 1'b0;
      end
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pulse_r <= 1'b0;
      level_r <= 1'b0;
    end else begin
      pulse_r <= pulse_s;
      level_r <= level_s;
    end
  end

  assign pulse = pulse_r;
  assign level = level_r;

endmodule

// File: rtl/battleship_input_conditioner.sv
// Battleship push-button front end: N_BTN independent conditioner channels
// producing one-cycle press/repeat pulses and debounced held levels.
module battleship_input_conditioner
  import battleship_input_pkg::*;
#(
  parameter int               N_BTN           = DEF_N_BTN,
  parameter bit               ACTIVE_LOW      = 1'b1,
  parameter int               DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int               REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int               REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [N_BTN-1:0] REPEAT_MASK     = N_BTN'(DEF_REPEAT_MASK)
) (
  input  logic                          clk,
  input  logic                          rst,
  battleship_input_conditioner_if.slave bus
);

  if (N_BTN < 1) begin : g_bad_n_btn
    $error("N_BTN must be at least 1");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 1");
  end
  if (REPEAT_PERIOD < 1) begin : g_bad_period
    $error("REPEAT_PERIOD must be at least 1");
  end
  if (REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_delay
    $error("REPEAT_DELAY must not be shorter than REPEAT_PERIOD");
  end

  logic [N_BTN-1:0] pulse_s;
  logic [N_BTN-1:0] level_s;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .ACTIVE_LOW      (ACTIVE_LOW),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_channel (
      .clk   (clk),
      .rst   (rst),
      .raw   (bus.btn_raw[i]),
      .pulse (pulse_s[i]),
      .level (level_s[i])
    );
  end

  assign bus.btn_pulse = pulse_s;
  assign bus.btn_level = level_s;

endmodule

// File: tb/tb_battleship_input_conditioner.sv
// Directed plus randomized bench for battleship_input_conditioner, checked every
// cycle against a run-length reference model of the debounce and repeat rules.
module tb_battleship_input_conditioner;
  import battleship_input_pkg::*;

  localparam int         DB   = 4;
  localparam int         RD   = 10;
  localparam int         RP   = 5;
  localparam logic [6:0] MASK = 7'b0001111;

  logic       clk;
  logic       rst;
  logic [6:0] press;
  int         n_cmp = 0;
  int         n_err = 0;
  int         edge_no = 0;

  // reference model state
  bit         d1 [7];
  bit         d2 [7];
  int         run1 [7];
  int         run0 [7];
  int         since [7];
  int         target [7];
  bit         held [7];
  logic [6:0] m_level;
  logic [6:0] m_pulse;

  // observation tracking
  int         first_pulse [7];
  int         last_pulse [7];
  int         pcnt [7];
  int         fall_edge [7];
  int         hold_left [7];
  logic [6:0] prev_level;

  battleship_input_conditioner_if #(.N_BTN(7)) bus ();

  battleship_input_conditioner #(
    .N_BTN           (7),
    .ACTIVE_LOW      (1'b1),
    .DEBOUNCE_CYCLES (DB),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .REPEAT_MASK     (MASK)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_vec(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b at edge %0d", tag, obs, exp, edge_no);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 7; c++) begin
      d1[c] = 1'b0; d2[c] = 1'b0;
      run1[c] = 0; run0[c] = 0;
      held[c] = 1'b0; since[c] = 0; target[c] = RD;
    end
    m_level = 7'b0;
    m_pulse = 7'b0;
  endtask

  // A press is accepted after DB+1 consecutive pressed samples at the FSM input,
  // a release after DB+1 consecutive released ones; repeats count held edges.
  task automatic model_edge(input logic [6:0] raw_now);
    bit s;
    logic [6:0] mask_v;
    mask_v  = MASK;
    m_pulse = 7'b0;
    if (!rst) begin
      model_reset();
    end else begin
      for (int c = 0; c < 7; c++) begin
        s = d2[c]; d2[c] = d1[c]; d1[c] = ~raw_now[c];
        if (s) begin run1[c]++; run0[c] = 0; end
        else begin run0[c]++; run1[c] = 0; end
        if (!m_level[c]) begin
          if (run1[c] == DB + 1) begin
            m_level[c] = 1'b1; m_pulse[c] = 1'b1;
            held[c] = 1'b1; since[c] = 0; target[c] = RD;
          end
        end else if (run0[c] == DB + 1) begin
          m_level[c] = 1'b0; held[c] = 1'b0;
        end else if (!s) begin
          held[c] = 1'b0;
        end else if (!held[c]) begin
          held[c] = 1'b1; since[c] = 0; target[c] = RD;
        end else if (mask_v[c]) begin
          since[c]++;
          if (since[c] == target[c]) begin
            m_pulse[c] = 1'b1; since[c] = 0; target[c] = RP;
          end
        end
      end
    end
  endtask

  task automatic clear_track();
    for (int c = 0; c < 7; c++) begin
      first_pulse[c] = -1; last_pulse[c] = -1; pcnt[c] = 0; fall_edge[c] = -1;
    end
  endtask

  task automatic set_press(input logic [6:0] p);
    press       = p;
    bus.btn_raw = ~p;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(bus.btn_raw);
    edge_no++;
    #1;
    chk_vec("btn_pulse", bus.btn_pulse, m_pulse);
    chk_vec("btn_level", bus.btn_level, m_level);
    for (int c = 0; c < 7; c++) begin
      if (bus.btn_pulse[c]) begin
        pcnt[c]++;
        if (first_pulse[c] < 0) first_pulse[c] = edge_no;
        last_pulse[c] = edge_no;
      end
      if (prev_level[c] && !bus.btn_level[c]) fall_edge[c] = edge_no;
    end
    prev_level = bus.btn_level;
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Called just after an edge: assert reset between edges and check outputs clear at once.
  task automatic async_reset();
    #2 rst = 1'b0;
    #1;
    chk_vec("async_rst_pulse", bus.btn_pulse, 7'b0);
    chk_vec("async_rst_level", bus.btn_level, 7'b0);
    model_reset();
    tick_n(2);
    #2 rst = 1'b1;
  endtask

  initial begin
    int t0;
    int t1;
    int b5;
    logic [6:0] p;
    b5 = int'(BTN_CONFIRM_COLOCATION);
    rst = 1'b1;
    set_press(7'b0);
    model_reset();
    clear_track();
    prev_level = 7'b0;
    #1 rst = 1'b0;
    #1;
    chk_vec("reset_pulse", bus.btn_pulse, 7'b0);
    chk_vec("reset_level", bus.btn_level, 7'b0);
    tick_n(3);
    #2 rst = 1'b1;
    tick_n(5);

    // clean press of confirm_colocation, no repeat
    clear_track(); set_press(7'b0100000); t0 = edge_no;
    tick_n(30);
    chk_int("b5_first_pulse_edge", first_pulse[b5] - t0, 7);
    set_press(7'b0); t1 = edge_no;
    tick_n(12);
    chk_int("b5_pulse_count", pcnt[b5], 1);
    chk_int("b5_level_fall_edge", fall_edge[b5] - t1, 7);

    // bounce on up: low 2, high 1, then stable low from edge 4
    clear_track(); t0 = edge_no;
    set_press(7'b0000001); tick_n(2);
    set_press(7'b0000000); tick_n(1);
    set_press(7'b0000001); tick_n(11);
    chk_int("b0_first_pulse_edge", first_pulse[0] - t0, 10);
    set_press(7'b0); tick_n(12);
    chk_int("b0_pulse_count", pcnt[0], 1);

    // long hold on left with auto-repeat
    clear_track(); set_press(7'b0000100); t0 = edge_no;
    tick_n(38);
    set_press(7'b0); tick_n(15);
    chk_int("b2_first_pulse_edge", first_pulse[2] - t0, 7);
    chk_int("b2_last_pulse_edge", last_pulse[2] - t0, 37);
    chk_int("b2_pulse_count", pcnt[2], 6);

    // two-cycle release glitch on down while held
    clear_track(); set_press(7'b0000010); t0 = edge_no;
    tick_n(12);
    set_press(7'b0); tick_n(2);
    set_press(7'b0000010); tick_n(14);
    set_press(7'b0); t1 = edge_no; tick_n(12);
    chk_int("b1_pulse_count", pcnt[1], 2);
    chk_int("b1_repeat_edge", last_pulse[1] - t0, 27);
    chk_int("b1_level_fall_edge", fall_edge[1] - t1, 7);

    // reset mid-ARMING and mid-HELD on confirm_attack, button kept pressed
    clear_track(); set_press(7'b1000000);
    tick_n(4);
    async_reset();
    clear_track(); t0 = edge_no;
    tick_n(12);
    chk_int("b6_after_rst1_pulse_edge", first_pulse[6] - t0, 7);
    async_reset();
    clear_track(); t0 = edge_no;
    tick_n(12);
    chk_int("b6_after_rst2_pulse_edge", first_pulse[6] - t0, 7);
    chk_int("b6_after_rst2_count", pcnt[6], 1);
    set_press(7'b0); tick_n(12);

    // simultaneous press of right and confirm_amount
    clear_track(); set_press(7'b0011000); t0 = edge_no;
    tick_n(8);
    chk_int("b3_first_pulse_edge", first_pulse[3] - t0, 7);
    chk_int("b4_first_pulse_edge", first_pulse[4] - t0, 7);
    set_press(7'b0); tick_n(12);
    chk_int("b3_pulse_count", pcnt[3], 1);
    chk_int("b4_pulse_count", pcnt[4], 1);

    // randomized bounces and holds on all channels
    p = 7'b0;
    for (int c = 0; c < 7; c++) hold_left[c] = int'($urandom_range(1, 25));
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < 7; c++) begin
        hold_left[c]--;
        if (hold_left[c] <= 0) begin
          p[c] = ~p[c];
          hold_left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40))
                                                     : int'($urandom_range(1, 8));
        end
      end
      set_press(p);
      tick();
      if (k == 700 || k == 1100) async_reset();
    end

    set_press(7'b0);
    tick_n(20);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/battleship_input_conditioner.md
# battleship_input_conditioner

Conditions the seven raw push-buttons of the Battleship board before they reach the game top level. Each button is synchronised, debounced and converted into a single-cycle press pulse and a clean held level. The four movement buttons optionally auto-repeat while held. Its outputs drive the game's `move_*` and `confirm_*` inputs, so each physical press moves the cursor or confirms exactly once.

## Interface
Parameters:
- `N_BTN`, 7: number of button channels.
- `ACTIVE_LOW`, 1: raw buttons read 0 when pressed (board KEYs); 0 means active-high.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required to accept a press or a release; ≥1.
- `REPEAT_DELAY`, 25000000: cycles from the initial pulse to the first repeat pulse; ≥ `REPEAT_PERIOD`.
- `REPEAT_PERIOD`, 10000000: cycles between repeat pulses; ≥1.
- `REPEAT_MASK`, 7'b0001111: per-channel auto-repeat enable.

Ports:
- `clk`, in, 1: single system clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `btn_raw`, in, `N_BTN`: asynchronous raw buttons. Bit map: 0 up, 1 down, 2 left, 3 right, 4 confirm_amount, 5 confirm_colocation, 6 confirm_attack.
- `btn_pulse`, out, `N_BTN`: one-cycle pulse per accepted press and per repeat.
- `btn_level`, out, `N_BTN`: debounced pressed level, active-high.

## Operation
- Per channel, `btn_raw` goes through a 2-FF synchroniser. It is then normalised to active-high `s` using `ACTIVE_LOW`.
- Per-channel FSM states: IDLE, ARMING, HELD, RELEASING.
  - IDLE: on `s`=1 go to ARMING and clear the counter.
  - ARMING: while `s`=1 the counter increments. When it reaches `DEBOUNCE_CYCLES`-1, go to HELD and register `btn_pulse`=1 for exactly one cycle. If `s`=0 at any point, return to IDLE with no pulse.
  - HELD: `btn_level`=1. If the channel is repeat-enabled, a repeat counter runs. The first repeat pulse comes `REPEAT_DELAY` cycles after the initial pulse, then one every `REPEAT_PERIOD` cycles. On `s`=0 go to RELEASING and clear the debounce counter.
  - RELEASING: `btn_level` stays 1. If `s` stays 0 for `DEBOUNCE_CYCLES` cycles, go to IDLE and drop `btn_level`. If `s` returns to 1 first, go back to HELD with no pulse, and the repeat counter restarts from the `REPEAT_DELAY` phase.
- Channels are fully independent. Simultaneous presses on several channels may pulse in the same cycle.
- Counters saturate. Their width is `$clog2` of the largest count plus 1, and no wrap-around is permitted.
- Reset, asynchronous, whether idle or mid-operation:
  - all FSMs go to IDLE;
  - all counters and synchroniser flops clear to the unpressed value;
  - `btn_pulse`=0 and `btn_level`=0.
  - A button held through reset release is re-debounced and yields one fresh pulse.

## Timing
- All outputs are registered. They are glitch-free and 0 during reset.
- Press latency: `btn_pulse` rises exactly `DEBOUNCE_CYCLES`+3 rising edges after the first edge that samples a stable pressed raw input. This is 2 edges of synchroniser, 1 for IDLE→ARMING, and the rest for the debounce count plus the output register.
- `btn_level` rises in the same cycle as the initial `btn_pulse`.
- `btn_level` falls `DEBOUNCE_CYCLES`+3 edges after a stable release.
- Minimum spacing between accepted presses on one channel is 2·`DEBOUNCE_CYCLES`+2 cycles.
- Pulse width is always exactly 1 cycle. The downstream game logic samples `btn_pulse` on `clk`.

## Structure
- Shared package `battleship_input_pkg`:
  - `btn_idx_e` enum for the bit map above;
  - `btn_state_e` typedef (IDLE, ARMING, HELD, RELEASING);
  - default debounce and repeat constants for a 50 MHz `clk`.
- One sub-module, `btn_channel`, holds the synchroniser, FSM and counters for one button. The top level instantiates it `N_BTN` times in a generate loop, with the repeat enable taken from `REPEAT_MASK[i]`.
- Elaboration-time assertions check the parameter constraints.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=10, `REPEAT_PERIOD`=5, `ACTIVE_LOW`=1.
- Clean press of bit 5, held 30 cycles → exactly one `btn_pulse[5]` at edge 7. `btn_level[5]` is high from edge 7 until 7 edges after release. Bit 5 is not repeat-enabled, so there are no repeats.
- Bounce on bit 0: low 2, high 1, low 2, then stable low → no pulse during the bounce. One pulse 7 edges after stable low begins.
- Hold bit 2 for 40 cycles → pulses at edges 7, 17, 22, 27, 32, 37, then none after release.
- Release glitch of 2 cycles in HELD on bit 1 → no new pulse and `btn_level[1]` stays high. The next repeat pulse comes 10 cycles after re-entry to HELD.
- Assert `rst`=0 mid-ARMING and mid-HELD on bit 6 → outputs go to 0 immediately, without waiting for a clock edge. After `rst`=1 with the button still held, one pulse arrives 7 edges later.
- Bits 3 and 4 pressed in the same cycle → both pulses occur in the same cycle, and the channels are otherwise unaffected by each other.
